// File: rtl/lsu_data_mem_responder_pkg.sv
// Shared types and helpers for the LSU data-memory responder.
// Holds the LSU request encodings and the byte-enable legality rule.
package lsu_data_mem_responder_pkg;

  localparam int unsigned LSU_DATA_WIDTH = 32;

  typedef enum logic {
    WeLoad  = 1'b0,
    WeStore = 1'b1
  } we_e;

  typedef enum logic [1:0] {
    TypeWord  = 2'b00,
    TypeHalf  = 2'b01,
    TypeByte1 = 2'b10,
    TypeByte2 = 2'b11
  } type_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StGrant
  } gnt_state_e;

  // Byte enables must exactly match the access size at the given byte offset.
  function automatic logic lsu_be_legal(input type_e t, input logic [1:0] addr,
                                        input logic [3:0] be);
    logic legal;
    unique case (t)
      TypeWord: legal = (addr == 2'b00) && (be == 4'b1111);
      TypeHalf: legal = !addr[0] && (be == (addr[1] ? 4'b1100 : 4'b0011));
      default:  legal = (be == (4'b0001 << addr));
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/lsu_resp_pipe.sv
// Fixed-latency response shift register carrying {valid, rdata, err}.
// Payload is zeroed when a stage is invalid so outputs are clean while idle.
module lsu_resp_pipe #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [Width-1:0] in_rdata,
  input  logic             in_err,
  output logic             out_valid,
  output logic [Width-1:0] out_rdata,
  output logic             out_err
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] err_q;
  logic [Width-1:0] rdata_q [Depth];

  always_ff @(posedge clk) begin
    if (flush) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & in_err;
      rdata_q[0] <= in_valid ? in_rdata : '0;
      for (int unsigned i = 1; i < Depth; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_err   = err_q[Depth-1];
  assign out_rdata = rdata_q[Depth-1];

endmodule

// File: rtl/lsu_data_mem_responder.sv
// Memory side of the LSU req/gnt/rvalid protocol: word RAM, grant delay FSM,
// legality check, fixed-latency responses and saturating statistics counters.
module lsu_data_mem_responder
  import lsu_data_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_WORDS = 1024,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RVALID_LATENCY  = 1,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic [31:0]          data_addr_i,
  input  logic                 data_we_i,
  input  logic [1:0]           data_type_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic [CNT_WIDTH-1:0] load_cnt_o,
  output logic [CNT_WIDTH-1:0] store_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned DlyW = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;

  gnt_state_e          state_q;
  logic [DlyW-1:0]     dly_cnt_q;
  logic [CNT_WIDTH-1:0] load_cnt_q, store_cnt_q, err_cnt_q;
  logic [LSU_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  logic [IdxW-1:0] idx;
  logic [31:0]     upper;
  logic            addr_ok, legal, accept, is_store, wr_en, pipe_flush;
  logic [31:0]     resp_rdata;

  assign idx      = data_addr_i[IdxW+1:2];
  assign upper    = data_addr_i >> (IdxW + 2);
  assign addr_ok  = (upper == '0) && (32'(idx) < MEM_DEPTH_WORDS);
  assign legal    = addr_ok && lsu_be_legal(type_e'(data_type_i), data_addr_i[1:0], data_be_i);
  assign is_store = (we_e'(data_we_i) == WeStore);

  assign data_gnt_o = (GNT_DELAY == 0) ? data_req_i : (data_req_i && (state_q == StGrant));
  assign accept     = data_req_i && data_gnt_o;
  assign wr_en      = accept && legal && is_store;

  // Each request pays the full delay; a dropped request abandons the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dly_cnt_q <= '0;
    end else if (GNT_DELAY != 0) begin
      unique case (state_q)
        StIdle: begin
          if (data_req_i) begin
            if (GNT_DELAY == 1) begin
              state_q <= StGrant;
            end else begin
              state_q   <= StWait;
              dly_cnt_q <= DlyW'(GNT_DELAY - 1);
            end
          end
        end
        StWait: begin
          if (!data_req_i) begin
            state_q <= StIdle;
          end else begin
            dly_cnt_q <= dly_cnt_q - 1'b1;
            if (dly_cnt_q == DlyW'(1)) state_q <= StGrant;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Asynchronous read: a load right after a store to the same word sees new data.
  assign resp_rdata = (legal && !is_store) ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (accept) begin
      if (!legal) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end else if (is_store) begin
        if (store_cnt_q != '1) store_cnt_q <= store_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (load_cnt_q != '1) load_cnt_q <= load_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign load_cnt_o  = load_cnt_q;
  assign store_cnt_o = store_cnt_q;
  assign err_cnt_o   = err_cnt_q;
  assign pipe_flush  = !rst_n;

  lsu_resp_pipe #(
    .Depth(RVALID_LATENCY),
    .Width(LSU_DATA_WIDTH)
  ) u_resp_pipe (
    .clk      (clk),
    .flush    (pipe_flush),
    .in_valid (accept),
    .in_rdata (resp_rdata),
    .in_err   (!legal),
    .out_valid(data_rvalid_o),
    .out_rdata(data_rdata_o),
    .out_err  (data_err_o)
  );

endmodule

// File: tb/tb_lsu_data_mem_responder.sv
// Scoreboard bench driving three responder configurations with directed vectors.
module tb_lsu_data_mem_responder;

  localparam logic [1:0] TW = 2'b00, TH = 2'b01, TB = 2'b10;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  logic        rst [3];
  logic        req [3];
  logic        we  [3];
  logic [1:0]  ty  [3];
  logic [31:0] addr[3];
  logic [3:0]  be  [3];
  logic [31:0] wd  [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic [15:0] lcnt[2];
  logic [15:0] scnt[2];
  logic [15:0] ecnt[2];
  logic [3:0]  lcnt_c, scnt_c, ecnt_c;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  lsu_data_mem_responder #(
    .MEM_DEPTH_WORDS(1024), .GNT_DELAY(0), .RVALID_LATENCY(1), .CNT_WIDTH(16)
  ) u_a (
    .clk(clk), .rst_n(rst[0]), .data_req_i(req[0]), .data_gnt_o(gnt[0]),
    .data_addr_i(addr[0]), .data_we_i(we[0]), .data_type_i(ty[0]), .data_be_i(be[0]),
    .data_wdata_i(wd[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0]), .load_cnt_o(lcnt[0]), .store_cnt_o(scnt[0]), .err_cnt_o(ecnt[0])
  );

  lsu_data_mem_responder #(
    .MEM_DEPTH_WORDS(1024), .GNT_DELAY(2), .RVALID_LATENCY(3), .CNT_WIDTH(16)
  ) u_b (
    .clk(clk), .rst_n(rst[1]), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
    .data_addr_i(addr[1]), .data_we_i(we[1]), .data_type_i(ty[1]), .data_be_i(be[1]),
    .data_wdata_i(wd[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1]), .load_cnt_o(lcnt[1]), .store_cnt_o(scnt[1]), .err_cnt_o(ecnt[1])
  );

  lsu_data_mem_responder #(
    .MEM_DEPTH_WORDS(64), .GNT_DELAY(0), .RVALID_LATENCY(3), .CNT_WIDTH(4)
  ) u_c (
    .clk(clk), .rst_n(rst[2]), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
    .data_addr_i(addr[2]), .data_we_i(we[2]), .data_type_i(ty[2]), .data_be_i(be[2]),
    .data_wdata_i(wd[2]), .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]),
    .data_err_o(err[2]), .load_cnt_o(lcnt_c), .store_cnt_o(scnt_c), .err_cnt_o(ecnt_c)
  );

  function automatic int lat(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int qsize(input int u);
    case (u)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int u);
    case (u)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int u, input exp_t e);
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Present a request, hold it until granted, and queue the expected response.
  task automatic issue(input int u, input logic w, input logic [1:0] t, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_err, output int st, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    req[u] = 1'b1; we[u] = w; ty[u] = t; addr[u] = a; be[u] = b; wd[u] = d;
    #1;
    st = cyc;
    n  = 0;
    while (!gnt[u] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc = cyc;
    if (!gnt[u]) begin
      tests++;
      fails++;
      $display("FAIL u%0d_gnt_timeout: no grant after %0d cycles, required a grant", u, n);
      req[u] = 1'b0;
    end else begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.cyc   = cyc + lat(u);
      qpush(u, e);
      @(posedge clk);
    end
  endtask

  task automatic drain(input int u);
    int n;
    n = 0;
    @(negedge clk);
    req[u] = 1'b0;
    while (qsize(u) != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (qsize(u) != 0) begin
      tests++;
      fails++;
      $display("FAIL u%0d_drain_timeout: %0d responses outstanding, required 0", u, qsize(u));
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 3; u++) begin
        if (rvalid[u]) begin
          if (qsize(u) == 0) begin
            tests++;
            fails++;
            $display("FAIL u%0d_unexpected_rvalid: got rvalid=1 in cycle %0d, required none",
                     u, cyc);
          end else begin
            exp_t e;
            e = qpop(u);
            chk($sformatf("u%0d_rdata", u), rdata[u], e.rdata);
            chk($sformatf("u%0d_err", u), 32'(err[u]), 32'(e.err));
            chk($sformatf("u%0d_rvalid_cycle", u), 32'(cyc), 32'(e.cyc));
          end
        end else if (rdata[u] != '0 || err[u]) begin
          chk($sformatf("u%0d_idle_payload", u), {rdata[u][31:1], rdata[u][0] | err[u]}, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, acc, acc1;
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b0; req[u] = 1'b0; we[u] = 1'b0; ty[u] = TW;
      addr[u] = '0; be[u] = '0; wd[u] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_reset_rvalid", u), 32'(rvalid[u]), 0);
      chk($sformatf("u%0d_reset_rdata", u), rdata[u], 0);
      chk($sformatf("u%0d_reset_err", u), 32'(err[u]), 0);
    end
    chk("a_reset_cnts", 32'(lcnt[0] | scnt[0] | ecnt[0]), 0);
    chk("b_reset_cnts", 32'(lcnt[1] | scnt[1] | ecnt[1]), 0);
    chk("c_reset_cnts", 32'(lcnt_c | scnt_c | ecnt_c), 0);
    for (int u = 0; u < 3; u++) rst[u] = 1'b1;
    mon_en = 1'b1;

    // Instance A: zero grant delay, one-cycle latency.
    issue(0, 1'b1, TW, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, st, acc);
    chk("a_gnt_same_cycle", 32'(acc - st), 0);
    issue(0, 1'b0, TW, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, st, acc);
    drain(0);
    chk("a_store_cnt_1", 32'(scnt[0]), 1);
    chk("a_load_cnt_1", 32'(lcnt[0]), 1);
    issue(0, 1'b1, TB, 32'h13, 4'b1000, 32'hAA000000, 32'h0, 1'b0, st, acc);
    issue(0, 1'b0, TH, 32'h12, 4'b1100, 32'h0, 32'hAAADBEEF, 1'b0, st, acc);
    issue(0, 1'b1, TW, 32'h0, 4'hF, 32'h11111111, 32'h0, 1'b0, st, acc);
    issue(0, 1'b1, TW, 32'h4, 4'hF, 32'h22222222, 32'h0, 1'b0, st, acc);
    issue(0, 1'b1, TW, 32'h2, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, st, acc);
    issue(0, 1'b1, TH, 32'h1, 4'b0011, 32'hFFFFFFFF, 32'h0, 1'b1, st, acc);
    issue(0, 1'b1, TB, 32'h5, 4'b0001, 32'hFFFFFFFF, 32'h0, 1'b1, st, acc);
    issue(0, 1'b1, TW, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, st, acc);
    issue(0, 1'b0, TW, 32'h10, 4'hF, 32'h0, 32'hAAADBEEF, 1'b0, st, acc);
    issue(0, 1'b0, TW, 32'h0, 4'hF, 32'h0, 32'h11111111, 1'b0, st, acc);
    issue(0, 1'b0, TW, 32'h4, 4'hF, 32'h0, 32'h22222222, 1'b0, st, acc);
    issue(0, 1'b1, TW, 32'h20, 4'hF, 32'h12345678, 32'h0, 1'b0, st, acc);
    issue(0, 1'b0, TW, 32'h20, 4'hF, 32'h0, 32'h12345678, 1'b0, st, acc);
    drain(0);
    chk("a_store_cnt", 32'(scnt[0]), 5);
    chk("a_load_cnt", 32'(lcnt[0]), 6);
    chk("a_err_cnt", 32'(ecnt[0]), 4);

    // Instance B: two-cycle grant delay, three-cycle latency.
    issue(1, 1'b1, TW, 32'h8, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, st, acc);
    chk("b_gnt_delay", 32'(acc - st), 2);
    acc1 = acc;
    issue(1, 1'b0, TW, 32'h8, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, st, acc);
    chk("b_b2b_full_delay", 32'(acc - acc1), 3);
    drain(1);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; ty[1] = TW; addr[1] = 32'h8; be[1] = 4'hF; wd[1] = 32'h0;
    #1;
    chk("b_no_early_gnt", 32'(gnt[1]), 0);
    @(negedge clk);
    req[1] = 1'b0;
    issue(1, 1'b0, TW, 32'h8, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, st, acc);
    chk("b_delay_after_drop", 32'(acc - st), 2);
    drain(1);
    chk("b_store_cnt", 32'(scnt[1]), 1);
    chk("b_load_cnt", 32'(lcnt[1]), 2);
    chk("b_err_cnt", 32'(ecnt[1]), 0);

    // Instance C: back-to-back stream, mid-stream reset, counter saturation.
    for (int i = 0; i < 5; i++)
      issue(2, 1'b1, TW, 32'(4 * i), 4'hF, 32'hA0000000 | 32'(i), 32'h0, 1'b0, st, acc);
    for (int i = 0; i < 5; i++)
      issue(2, 1'b0, TW, 32'(4 * i), 4'hF, 32'h0, 32'hA0000000 | 32'(i), 1'b0, st, acc);
    drain(2);
    chk("c_store_cnt", 32'(scnt_c), 5);
    chk("c_load_cnt", 32'(lcnt_c), 5);
    issue(2, 1'b0, TW, 32'h0, 4'hF, 32'h0, 32'hA0000000, 1'b0, st, acc);
    issue(2, 1'b0, TW, 32'h4, 4'hF, 32'h0, 32'hA0000001, 1'b0, st, acc);
    @(negedge clk);
    req[2] = 1'b0;
    rst[2] = 1'b0;
    q2.delete();
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    chk("c_rst_load_cnt", 32'(lcnt_c), 0);
    chk("c_rst_store_cnt", 32'(scnt_c), 0);
    chk("c_rst_err_cnt", 32'(ecnt_c), 0);
    repeat (6) begin
      @(negedge clk);
      #1;
      chk("c_no_rvalid_after_rst", 32'(rvalid[2]), 0);
    end
    issue(2, 1'b0, TW, 32'h8, 4'hF, 32'h0, 32'hA0000002, 1'b0, st, acc);
    drain(2);
    chk("c_load_cnt_after_rst", 32'(lcnt_c), 1);
    for (int i = 0; i < 14; i++)
      issue(2, 1'b1, TW, 32'h100, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, st, acc);
    drain(2);
    chk("c_err_cnt_14", 32'(ecnt_c), 32'hE);
    for (int i = 0; i < 3; i++)
      issue(2, 1'b1, TH, 32'h3, 4'b1100, 32'hFFFFFFFF, 32'h0, 1'b1, st, acc);
    drain(2);
    chk("c_err_cnt_sat", 32'(ecnt_c), 32'hF);
    chk("c_store_cnt_after_err", 32'(scnt_c), 0);
    issue(2, 1'b0, TW, 32'h0, 4'hF, 32'h0, 32'hA0000000, 1'b0, st, acc);
    drain(2);
    chk("c_err_cnt_held", 32'(ecnt_c), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_data_mem_responder.md
Name: lsu_data_mem_responder

Overview:
Data-memory responder for the core's LSU data interface. It is the memory side of the req/gnt/rvalid protocol that the LSU drives using we_e, type_e and byte enables. It holds a word-addressed RAM, inserts a configurable grant delay and a fixed read latency, checks each request for legality, and keeps transaction counters. It is used as the data memory in core-level simulation and as a synthesizable scratchpad.

Parameters:
MEM_DEPTH_WORDS, 1024, number of 32-bit words; word index is data_addr_i[$clog2(MEM_DEPTH_WORDS)+1:2]
GNT_DELAY, 0, idle cycles between req rising and gnt (0 = same-cycle grant)
RVALID_LATENCY, 1, cycles from the grant cycle to rvalid; legal range is >= 1
CNT_WIDTH, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
data_req_i  in  1  LSU request valid
data_gnt_o  out  1  request accepted this cycle
data_addr_i  in  32  byte address
data_we_i  in  1  we_e: LOAD=0, STORE=1
data_type_i  in  2  type_e: WORD, HALF, BYTE1/BYTE2 (both mean byte)
data_be_i  in  4  byte enables
data_wdata_i  in  32  store data, already lane-aligned
data_rvalid_o  out  1  response valid, one cycle per granted request
data_rdata_o  out  32  raw aligned word; LSU performs extension
data_err_o  out  1  response error, qualified by rvalid
load_cnt_o  out  CNT_WIDTH  granted legal loads, saturating
store_cnt_o  out  CNT_WIDTH  granted legal stores, saturating
err_cnt_o  out  CNT_WIDTH  error responses, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, grant FSM to IDLE, response pipeline flushed, counters 0. RAM contents are not affected by reset.
- Grant FSM states: IDLE, WAIT, GRANT.
  - GNT_DELAY=0: data_gnt_o = data_req_i, combinational; the FSM stays in IDLE.
  - GNT_DELAY>0, IDLE: on req go to WAIT and load the counter with GNT_DELAY-1.
  - GNT_DELAY>0, WAIT: decrement the counter; at 0 go to GRANT.
  - GNT_DELAY>0, GRANT: gnt = req for one cycle, then return to IDLE.
  - If req drops in WAIT or GRANT (protocol violation), return to IDLE. No transaction occurs.
- Back-to-back requests with GNT_DELAY>0: each request pays the full delay.
- Accept: a transaction occurs in any cycle where gnt=1 and req=1. At most one transaction per cycle.
- Legality check, evaluated at accept. A request is illegal if any of these holds:
  - word index >= MEM_DEPTH_WORDS, or any address bit above the index range is nonzero;
  - WORD and (addr[1:0]!=0 or be!=4'b1111);
  - HALF and (addr[0]!=0 or be != (addr[1] ? 4'b1100 : 4'b0011));
  - BYTE and be != (4'b0001 << addr[1:0]).
- Legal STORE: write the enabled bytes of wdata into RAM at the accept edge. The response carries rdata=0, err=0.
- Legal LOAD: read the full word at accept. A load accepted in the cycle after a store to the same word returns the new data.
- Illegal request: RAM is not written. The response carries rdata=0, err=1.
- Response pipeline: a shift register of RVALID_LATENCY stages, each holding {valid, rdata, err}.
  - A request accepted in cycle N produces rvalid=1 in cycle N+RVALID_LATENCY, for exactly one cycle.
  - Responses come back in order. The pipeline can never overflow because there is at most one accept per cycle.
- rdata and err are 0 whenever rvalid=0.
- Counters increment at the accept edge:
  - load_cnt_o for legal loads;
  - store_cnt_o for legal stores;
  - err_cnt_o for every illegal request.
  - Counters saturate at all-ones; they do not wrap.
- Reset mid-operation: pending responses are dropped and no rvalid is issued for them. Stores already accepted remain in RAM.

Decomposition:
- riscv_pkg additions:
  - function lsu_be_legal(type_e, addr[1:0], be) returning bit;
  - parameter LSU_DATA_WIDTH=32.
- Reuse we_e and type_e from riscv_pkg unchanged.
- Sub-module lsu_resp_pipe holds the parameterised-depth {valid, rdata, err} shift register with synchronous flush. The top level holds the FSM, RAM, legality check and counters.

Test Plan:
- GNT_DELAY=0, LATENCY=1: store WORD addr 0x10 wdata 0xDEADBEEF be 4'hF; then load WORD 0x10 -> gnt same cycle as each req; rvalid 1 cycle after each gnt; load rdata 0xDEADBEEF, err 0; store_cnt=1, load_cnt=1.
- Store BYTE1 addr 0x13 be 4'b1000 wdata 0xAA000000 over 0xDEADBEEF; load HALF 0x12 be 4'b1100 -> rdata 0xAAADBEEF.
- Illegal requests, one per cycle: WORD addr 0x2 be F; HALF addr 0x1; BYTE addr 0x5 be 4'b0001; addr 4*MEM_DEPTH_WORDS -> four rvalid with err=1, rdata=0; RAM unchanged; err_cnt=4.
- GNT_DELAY=2, LATENCY=3: req held from cycle 0 -> gnt in cycle 2, rvalid in cycle 5; req dropped in cycle 1 -> no gnt, no rvalid, counters unchanged.
- LATENCY=3, five back-to-back loads with GNT_DELAY=0 -> five consecutive rvalid cycles in issue order with the correct data; rst_n low for one cycle mid-stream -> no further rvalid and all counters read 0.
- Force err_cnt_o to all-ones minus 1 (CNT_WIDTH=4), issue 3 illegal requests -> err_cnt_o=4'hF and stays there.
